// File: rtl/avalon_adapter_pkg.sv
// Shared types for the Avalon-MM 32-to-16 bit adapters (write side now, read side to follow).
package avalon_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } wr_state_t;

    localparam int ADDR_W_DEFAULT      = 27;
    localparam int HALF_OFFSET_DEFAULT = 2;

endpackage

// File: rtl/avalon_mm_32to16_write_adapter_if.sv
// Bus bundle for the write adapter: 32-bit slave-side command port and 16-bit master-side port.
// The slave modport is the adapter's view; the master modport is the Nios II / memory side around it.
interface avalon_mm_32to16_write_adapter_if #(
    parameter int ADDR_W = 27
);

    logic [ADDR_W-1:0] s_address;
    logic              s_write;
    logic [31:0]       s_writedata;
    logic [3:0]        s_byteenable;
    logic              s_lock;
    logic              s_waitrequest;

    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [15:0]       m_writedata;
    logic [1:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_waitrequest;
    logic              m_lock;

    modport slave (
        input  s_address, s_write, s_writedata, s_byteenable, s_lock, m_waitrequest,
        output s_waitrequest, m_address, m_write, m_writedata, m_byteenable, m_chipselect, m_lock
    );

    modport master (
        output s_address, s_write, s_writedata, s_byteenable, s_lock, m_waitrequest,
        input  s_waitrequest, m_address, m_write, m_writedata, m_byteenable, m_chipselect, m_lock
    );

endinterface

// File: rtl/avalon_mm_32to16_write_adapter.sv
// Splits one 32-bit Avalon-MM write into up to two 16-bit writes (low half at A, high half at
// A+HALF_OFFSET), issuing only the halves whose byte enables are set.
module avalon_mm_32to16_write_adapter
    import avalon_adapter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int HALF_OFFSET = HALF_OFFSET_DEFAULT
) (
    input logic                              clock,
    input logic                              reset_n,
    avalon_mm_32to16_write_adapter_if.slave  bus
);

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [15:0]       writedata;
        logic [1:0]        byteenable;
    } half_cmd_t;

    // Address wraps modulo 2^ADDR_W; any carry out of the top bit is dropped.
    function automatic half_cmd_t half_cmd(
        input logic              high,
        input logic [ADDR_W-1:0] addr,
        input logic [31:0]       data,
        input logic [3:0]        be
    );
        half_cmd_t c;
        if (high) begin
            c.address    = addr + ADDR_W'(HALF_OFFSET);
            c.writedata  = data[31:16];
            c.byteenable = be[3:2];
        end else begin
            c.address    = addr;
            c.writedata  = data[15:0];
            c.byteenable = be[1:0];
        end
        return c;
    endfunction

    wr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [31:0]       lat_data_q, lat_data_d;
    logic [3:0]        lat_be_q, lat_be_d;
    half_cmd_t         cmd_q, cmd_d;
    logic              m_write_q, m_write_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_be_q   <= '0;
            cmd_q      <= '0;
            m_write_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            lat_be_q   <= lat_be_d;
            cmd_q      <= cmd_d;
            m_write_q  <= m_write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        lat_be_d   = lat_be_q;
        cmd_d      = cmd_q;
        m_write_d  = m_write_q;

        case (state_q)
            IDLE: begin
                if (bus.s_write) begin
                    lat_addr_d = bus.s_address;
                    lat_data_d = bus.s_writedata;
                    lat_be_d   = bus.s_byteenable;
                    if (bus.s_byteenable[1:0] != 2'b00) begin
                        cmd_d     = half_cmd(1'b0, bus.s_address, bus.s_writedata, bus.s_byteenable);
                        m_write_d = 1'b1;
                        state_d   = LO;
                    end else if (bus.s_byteenable[3:2] != 2'b00) begin
                        cmd_d     = half_cmd(1'b1, bus.s_address, bus.s_writedata, bus.s_byteenable);
                        m_write_d = 1'b1;
                        state_d   = HI;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            // An abandoned slave write still finishes the half in flight, then skips the rest.
            LO: begin
                if (!bus.m_waitrequest) begin
                    if (bus.s_write && (lat_be_q[3:2] != 2'b00)) begin
                        cmd_d   = half_cmd(1'b1, lat_addr_q, lat_data_q, lat_be_q);
                        state_d = HI;
                    end else begin
                        m_write_d = 1'b0;
                        state_d   = bus.s_write ? DONE : IDLE;
                    end
                end
            end
            HI: begin
                if (!bus.m_waitrequest) begin
                    m_write_d = 1'b0;
                    state_d   = bus.s_write ? DONE : IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_waitrequest = bus.s_write & (state_q != DONE);
    assign bus.m_address     = cmd_q.address;
    assign bus.m_writedata   = cmd_q.writedata;
    assign bus.m_byteenable  = cmd_q.byteenable;
    assign bus.m_write       = m_write_q;
    assign bus.m_chipselect  = m_write_q;
    assign bus.m_lock        = bus.s_lock;

endmodule
